// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared constants for the RV32M iterative mul/div unit.
// Holds the M-extension encodings, FSM state codes and operand-sign helpers.
package ex_muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage request/response bundle of the mul/div unit.
// master = EX stage / ID-EX side, slave = the unit itself.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);

  logic            req_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output req_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  req_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_o
  );

endinterface

// File: rtl/ex_muldiv_unit_negate.sv
// muldiv_negate: conditional two's complement.
// Used for operand magnitudes and the final sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide, 1 bit per cycle.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = ex_muldiv_unit_pkg::XLEN,
  parameter int CNT_W = ex_muldiv_unit_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              start_i,
  ex_muldiv_unit_if.slave   mdu
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, mul_nxt, div_nxt;
  logic [XLEN-1:0]   op_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [4:0]        rd_lat_q, rd_q;
  logic [XLEN-1:0]   result_q;

  logic [2:0]        f3;
  logic              sa, sb, accept, last;
  logic              div0, ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, special_res;
  logic [XLEN:0]     mul_sum, trial, diff;
  logic              ge;
  logic [2*XLEN-1:0] raw, fixed;
  logic [XLEN-1:0]   fin;

  assign f3 = mdu.funct3_i;
  assign sa = mdu.rs1_i[XLEN-1] & op_signed_a(f3);
  assign sb = mdu.rs2_i[XLEN-1] & op_signed_b(f3);

  muldiv_negate #(.W(XLEN)) u_abs_a (
    .val_i(mdu.rs1_i), .neg_i(sa), .val_o(abs_a)
  );

  muldiv_negate #(.W(XLEN)) u_abs_b (
    .val_i(mdu.rs2_i), .neg_i(sb), .val_o(abs_b)
  );

  assign accept = (state_q == S_IDLE) & mdu.req_i & ~mdu.flush_i;
  assign last   = (cnt_q == '0);

  // RISC-V defined results: divide by zero and signed overflow
  assign div0    = (mdu.rs2_i == '0);
  assign ovf     = ~f3[0] & (mdu.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (&mdu.rs2_i);
  assign special = f3[2] & (div0 | ovf);
  assign special_res = f3[1] ? (div0 ? mdu.rs1_i : '0)
                             : (div0 ? '1 : mdu.rs1_i);

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, op_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  assign trial   = acc_q[2*XLEN-1:XLEN-1];
  assign ge      = trial >= {1'b0, op_q};
  assign diff    = trial - {1'b0, op_q};
  assign div_nxt = {ge ? diff[XLEN-1:0] : trial[XLEN-1:0],
                    acc_q[XLEN-2:0], ge};

  assign acc_nxt = (state_q == S_MUL) ? mul_nxt : div_nxt;

  always_comb begin
    raw = acc_nxt;
    if (f3_q[2]) begin
      raw = f3_q[1] ? {{XLEN{1'b0}}, acc_nxt[2*XLEN-1:XLEN]}
                    : {{XLEN{1'b0}}, acc_nxt[XLEN-1:0]};
    end
  end

  // Sign fix-up runs on the full product so MULH* high halves are exact
  muldiv_negate #(.W(2*XLEN)) u_fix (
    .val_i(raw), .neg_i(neg_q), .val_o(fixed)
  );

  assign fin = (f3_q[2] || f3_q == F3_MUL) ? fixed[XLEN-1:0]
                                           : fixed[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE
                                  : (f3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (mdu.flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_lat_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= CNT_W'(XLEN-1);
        op_q     <= f3[2] ? abs_b : abs_a;
        acc_q    <= {{XLEN{1'b0}}, f3[2] ? abs_a : abs_b};
        f3_q     <= f3;
        neg_q    <= (f3[2] & f3[1]) ? sa : (sa ^ sb);
        rd_lat_q <= mdu.rd_i;
        if (special) begin
          result_q <= special_res;
          rd_q     <= mdu.rd_i;
        end
      end else if ((state_q == S_MUL || state_q == S_DIV)
                   && !mdu.flush_i) begin
        acc_q <= acc_nxt;
        if (last) begin
          result_q <= fin;
          rd_q     <= rd_lat_q;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign mdu.busy_o   = (state_q != S_IDLE);
  assign mdu.done_o   = (state_q == S_DONE) & ~mdu.flush_i;
  assign mdu.stall_o  = start_i & ~mdu.flush_i &
                        (((state_q == S_IDLE) & mdu.req_i) |
                         (state_q == S_MUL) | (state_q == S_DIV));
  assign mdu.result_o = result_q;
  assign mdu.rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed + random checks of ex_muldiv_unit
// against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;

  logic clk;
  logic start;
  int   total, bad, cyc;
  logic [31:0] last_exp;
  int   done_cyc;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit u_dut (
    .clk_i  (clk),
    .start_i(start),
    .mdu    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic is_special(input logic [2:0] f3,
                                      input logic [31:0] a, b);
    if (!f3[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_fn(input logic [2:0] f3,
                                         input logic [31:0] a, b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    up = {32'd0, a} * {32'd0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: return up[31:0];
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(f3, a, b)) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (is_special(f3, a, b)) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, b,
                       input logic [4:0] rd);
    logic [31:0] exp;
    int lat, n, st;
    exp = ref_fn(f3, a, b);
    lat = is_special(f3, a, b) ? 1 : 33;
    bus.req_i    = 1'b1;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    bus.rd_i     = rd;
    #1;
    chk("stall_acc", 64'(bus.stall_o), 64'd1);
    st = 1;
    n  = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.done_o) break;
      if (bus.stall_o) st++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("stall_cnt", 64'(st), 64'(lat));
    chk("result", 64'(bus.result_o), 64'(exp));
    chk("rd", 64'(bus.rd_o), 64'(rd));
    chk("stall_done", 64'(bus.stall_o), 64'd0);
    last_exp = exp;
    done_cyc = cyc;
  endtask

  task automatic finish_op();
    step();
    bus.req_i = 1'b0;
    #1;
    chk("done_pulse", 64'(bus.done_o), 64'd0);
    chk("no_reacc", 64'(bus.busy_o), 64'd0);
    chk("hold", 64'(bus.result_o), 64'(last_exp));
  endtask

  initial begin
    int d1;
    logic [31:0] a, b;
    total = 0;
    bad   = 0;
    cyc   = 0;
    start = 1'b0;
    bus.req_i    = 1'b0;
    bus.funct3_i = 3'd0;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    bus.rd_i     = '0;
    bus.flush_i  = 1'b0;
    #12;
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_res", 64'(bus.result_o), 64'd0);
    chk("rst_rd", 64'(bus.rd_o), 64'd0);
    @(negedge clk);
    start = 1'b1;
    step();

    do_op(3'd0, 32'd7, 32'd6, 5'd5);            finish_op();
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6); finish_op();
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7); finish_op();
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);    finish_op();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);    finish_op();
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);   finish_op();
    do_op(3'd5, 32'd100, 32'd7, 5'd11);         finish_op();
    do_op(3'd7, 32'd100, 32'd7, 5'd12);         finish_op();
    do_op(3'd4, 32'd5, 32'd0, 5'd13);           finish_op();
    do_op(3'd6, 32'd5, 32'd0, 5'd14);           finish_op();
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15); finish_op();
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16); finish_op();

    // flush in the middle of a DIVU
    bus.req_i    = 1'b1;
    bus.funct3_i = 3'd5;
    bus.rs1_i    = 32'd1000;
    bus.rs2_i    = 32'd3;
    bus.rd_i     = 5'd17;
    for (int i = 0; i < 10; i++) step();
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(bus.stall_o), 64'd0);
    chk("flush_done", 64'(bus.done_o), 64'd0);
    step();
    bus.flush_i = 1'b0;
    #1;
    chk("flush_idle", 64'(bus.busy_o), 64'd0);
    do_op(3'd0, 32'd3, 32'd3, 5'd18);           finish_op();

    // asynchronous reset mid-multiply
    bus.req_i    = 1'b1;
    bus.funct3_i = 3'd0;
    bus.rs1_i    = 32'd12345;
    bus.rs2_i    = 32'd678;
    bus.rd_i     = 5'd19;
    for (int i = 0; i < 5; i++) step();
    #2;
    start = 1'b0;
    #1;
    chk("arst_stall", 64'(bus.stall_o), 64'd0);
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_done", 64'(bus.done_o), 64'd0);
    chk("arst_res", 64'(bus.result_o), 64'd0);
    chk("arst_rd", 64'(bus.rd_o), 64'd0);
    bus.req_i = 1'b0;
    @(negedge clk);
    start = 1'b1;
    step();

    // back-to-back MUL then DIVU
    do_op(3'd0, 32'd1234, 32'd5678, 5'd20);
    d1 = done_cyc;
    step();
    do_op(3'd5, 32'd99999, 32'd123, 5'd21);
    chk("b2b_gap", 64'(done_cyc - d1), 64'd34);
    finish_op();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      int sel;
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin
        a = 32'($urandom_range(0, 200)) - 32'd100;
        b = 32'($urandom_range(1, 20));
      end
      do_op(f3, a, b, 5'($urandom_range(0, 31)));
      if (i == 39 || $urandom_range(0, 1) == 1) finish_op();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
